// File: rtl/mulacc_pkg.sv
// mulacc_pkg: shared constants and types for the multiplier_acc shift-add MAC unit.
//   - operand / result / counter widths
//   - final bit-count value
//   - FSM state encoding
package mulacc_pkg;

   localparam int unsigned OpW  = 8;   // operand width (A, B, C)
   localparam int unsigned ResW = 16;  // result width
   localparam int unsigned CntW = 3;   // bit counter width

   localparam logic [CntW-1:0] LastCnt = 3'd7;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

endpackage

// File: rtl/multiplier_acc.sv
// multiplier_acc: sequential shift-add multiply-accumulate, PRODUCT = A * B + C (unsigned).
// One multiplier bit is processed per clock; result after 8 run cycles.
//
// Ports:
//   CLK_1ms      in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   START        in   request, sampled only while idle
//   MULTIPLICAND in 8 operand A
//   MULTIPLIER   in 8 operand B
//   ADDEND       in 8 operand C
//   PRODUCT      out 16 result, held until next completion
//   BUSY         out  operation in progress
//   DONE         out  one-cycle completion pulse
//   ZF           out  PRODUCT == 0, updated with DONE
//   RERR         out  remainder-check flag
//
// Optional feature macro: MULACC_REMCHECK_EN
//   defined   : RERR flags operand sets with C >= A or A == 0 (not a valid division result)
//   undefined : RERR tied to 0
module multiplier_acc
   import mulacc_pkg::*;
(
   input  logic            CLK_1ms,
   input  logic            RST,
   input  logic            START,
   input  logic [OpW-1:0]  MULTIPLICAND,
   input  logic [OpW-1:0]  MULTIPLIER,
   input  logic [OpW-1:0]  ADDEND,
   output logic [ResW-1:0] PRODUCT,
   output logic            BUSY,
   output logic            DONE,
   output logic            ZF,
   output logic            RERR
);

   state_e             state_q, state_d;
   logic [OpW-1:0]     a_q, a_d;
   logic [OpW-1:0]     b_q, b_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [ResW-1:0]    acc_q, acc_d;
   logic [ResW-1:0]    product_q, product_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               zf_q, zf_d;

   logic [ResW-1:0]    partial;
   logic [ResW-1:0]    acc_sum;

`ifdef MULACC_REMCHECK_EN
   logic               chk_q, chk_d;
   logic               rerr_q, rerr_d;
`endif

   // Partial product: A shifted to the weight of the current multiplier bit.
   always_comb begin
      partial = '0;
      if (b_q[0]) begin
         partial = {{(ResW-OpW){1'b0}}, a_q} << cnt_q;
      end
      acc_sum = acc_q + partial;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      product_d = product_q;
      busy_d    = busy_q;
      zf_d      = zf_q;
      done_d    = 1'b0;
`ifdef MULACC_REMCHECK_EN
      chk_d     = chk_q;
      rerr_d    = rerr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (START) begin
               a_d     = MULTIPLICAND;
               b_d     = MULTIPLIER;
               acc_d   = {{(ResW-OpW){1'b0}}, ADDEND};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StRun;
`ifdef MULACC_REMCHECK_EN
               chk_d   = (ADDEND >= MULTIPLICAND) || (MULTIPLICAND == '0);
`endif
            end
         end
         StRun: begin
            acc_d = acc_sum;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               product_d = acc_sum;
               zf_d      = (acc_sum == '0);
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = StIdle;
`ifdef MULACC_REMCHECK_EN
               rerr_d    = chk_q;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK_1ms or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         zf_q      <= 1'b0;
`ifdef MULACC_REMCHECK_EN
         chk_q     <= 1'b0;
         rerr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         zf_q      <= zf_d;
`ifdef MULACC_REMCHECK_EN
         chk_q     <= chk_d;
         rerr_q    <= rerr_d;
`endif
      end
   end

   assign PRODUCT = product_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign ZF      = zf_q;
`ifdef MULACC_REMCHECK_EN
   assign RERR    = rerr_q;
`else
   assign RERR    = 1'b0;
`endif

endmodule
